// File: rtl/alu_op_dispatcher_if.sv
// Command and result handshake bundle for the ALU op dispatcher.
// The master side produces commands and consumes results; the slave side
// is the dispatcher itself.
interface alu_op_dispatcher_if #(
    parameter int OP_W = 4
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [OP_W-1:0]        cmd_a;
    logic [OP_W-1:0]        cmd_b;
    logic                   res_valid;
    logic                   res_ready;
    logic [2*OP_W-1:0]      res_data;
    logic                   res_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_err
    );
endinterface

// File: rtl/alu_op_dispatcher.sv
// Upstream command stage for the operand-isolated 4-op ALU.
// Commands are queued in a small FIFO, issued one at a time as a single
// select plus operands held for the ALU's two-cycle pipeline, and the ALU
// result is captured and offered on a valid/ready result port. Selects and
// operands sit at zero whenever nothing is in flight so idle ALU lanes see
// constant operands.
module alu_op_dispatcher #(
    parameter int OP_W       = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    alu_op_dispatcher_if.slave  bus,
    output logic                sel1,
    output logic                sel2,
    output logic                sel3,
    output logic                sel4,
    output logic [OP_W-1:0]     op_a,
    output logic [OP_W-1:0]     op_b,
    input  logic [2*OP_W-1:0]   alu_out,
    output logic                busy
);

    localparam int RES_W = 2 * OP_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_DIV = 2'd2;
    localparam logic [1:0] OP_SUB = 2'd3;

    // Substitute result for a divide by zero; the only value generated here.
    localparam logic [RES_W-1:0] RES_DIV0 = {RES_W{1'b1}};

    typedef struct packed {
        logic [1:0]      op;
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_HOLD  = 3'd2,
        ST_CAPT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // One-hot lane select for an opcode: bit 0 = MUL ... bit 3 = SUB.
    function automatic logic [3:0] op_onehot(input logic [1:0] op);
        logic [3:0] sel;
        case (op)
            OP_MUL:  sel = 4'b0001;
            OP_ADD:  sel = 4'b0010;
            OP_DIV:  sel = 4'b0100;
            OP_SUB:  sel = 4'b1000;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    // Command FIFO storage and pointers
    cmd_t              fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    cmd_t              head_s;
    logic              div_zero_s;

    // Dispatcher FSM and registered outputs
    state_t            state_r;
    logic [3:0]        sel_r;
    logic [OP_W-1:0]   op_a_r;
    logic [OP_W-1:0]   op_b_r;
    logic              err_pend_r;
    logic              res_valid_r;
    logic [RES_W-1:0]  res_data_r;
    logic              res_err_r;

    // Full/empty come from registered count only, so a pop can never make
    // room for a push in the same cycle when the FIFO is full.
    assign full_s     = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty_s    = (count_r == {CNT_W{1'b0}});
    assign push_s     = bus.cmd_valid && !full_s;
    assign pop_s      = (state_r == ST_IDLE) && !empty_s;
    assign head_s     = fifo_mem_r[rd_ptr_r];
    assign div_zero_s = (head_s.op == OP_DIV) && (head_s.b == {OP_W{1'b0}});

    // FIFO: write at tail on push, advance head on pop, track occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= cmd_t'({CMD_W{1'b0}});
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Dispatcher FSM: issue one op, hold it two cycles, isolate, capture, hand off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            sel_r       <= 4'b0000;
            op_a_r      <= {OP_W{1'b0}};
            op_b_r      <= {OP_W{1'b0}};
            err_pend_r  <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= {RES_W{1'b0}};
            res_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!empty_s) begin
                        // A divide by zero never reaches the ALU: lanes stay
                        // isolated and the substitute result is flagged.
                        if (div_zero_s) begin
                            sel_r      <= 4'b0000;
                            op_a_r     <= {OP_W{1'b0}};
                            op_b_r     <= {OP_W{1'b0}};
                            err_pend_r <= 1'b1;
                        end else begin
                            sel_r      <= op_onehot(head_s.op);
                            op_a_r     <= head_s.a;
                            op_b_r     <= head_s.b;
                            err_pend_r <= 1'b0;
                        end
                        state_r <= ST_ISSUE;
                    end else begin
                        sel_r  <= 4'b0000;
                        op_a_r <= {OP_W{1'b0}};
                        op_b_r <= {OP_W{1'b0}};
                    end
                end
                ST_ISSUE: begin
                    // ALU lane register captures at the end of this cycle.
                    state_r <= ST_HOLD;
                end
                ST_HOLD: begin
                    // ALU output register loads at this edge; isolate lanes.
                    sel_r   <= 4'b0000;
                    op_a_r  <= {OP_W{1'b0}};
                    op_b_r  <= {OP_W{1'b0}};
                    state_r <= ST_CAPT;
                end
                ST_CAPT: begin
                    res_data_r  <= err_pend_r ? RES_DIV0 : alu_out;
                    res_err_r   <= err_pend_r;
                    res_valid_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        err_pend_r  <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        res_valid_r <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encodings recover to a clean idle.
                    state_r     <= ST_IDLE;
                    sel_r       <= 4'b0000;
                    op_a_r      <= {OP_W{1'b0}};
                    op_b_r      <= {OP_W{1'b0}};
                    err_pend_r  <= 1'b0;
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign sel1          = sel_r[0];
    assign sel2          = sel_r[1];
    assign sel3          = sel_r[2];
    assign sel4          = sel_r[3];
    assign op_a          = op_a_r;
    assign op_b          = op_b_r;
    assign bus.cmd_ready = !full_s;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;
    assign bus.res_err   = res_err_r;
    assign busy          = (state_r != ST_IDLE) || !empty_s;

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Self-checking bench for alu_op_dispatcher: a small registered ALU stand-in
// drives alu_out, a queue of expected results is built from plain arithmetic
// on each accepted command, and a negedge monitor checks lane selects,
// operand isolation, select width and every delivered result.
module tb_alu_op_dispatcher;

    localparam int OP_W       = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int RES_W      = 2 * OP_W;

    typedef struct {
        logic [1:0]       op;
        logic [OP_W-1:0]  a;
        logic [OP_W-1:0]  b;
        logic [RES_W-1:0] data;
        logic             err;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             sel1;
    logic             sel2;
    logic             sel3;
    logic             sel4;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic [RES_W-1:0] alu_out;
    logic [RES_W-1:0] alu_stage_r;
    logic             busy;
    logic [3:0]       sel_vec;

    int   tests;
    int   fails;
    exp_t exp_q[$];
    int   sel_run;
    logic sel_prev;

    alu_op_dispatcher_if #(.OP_W(OP_W)) bus ();

    alu_op_dispatcher #(
        .OP_W       (OP_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .sel1    (sel1),
        .sel2    (sel2),
        .sel3    (sel3),
        .sel4    (sel4),
        .op_a    (op_a),
        .op_b    (op_b),
        .alu_out (alu_out),
        .busy    (busy)
    );

    assign sel_vec = {sel4, sel3, sel2, sel1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: lane result registered, then output register.
    function automatic logic [RES_W-1:0] alu_lane(input logic [3:0] s,
                                                  input logic [OP_W-1:0] a,
                                                  input logic [OP_W-1:0] b);
        logic [RES_W-1:0] r;
        case (s)
            4'b0001: r = {4'h0, a} * {4'h0, b};
            4'b0010: r = {4'h0, a} + {4'h0, b};
            4'b0100: r = (b != 4'h0) ? {4'h0, a / b} : 8'h00;
            4'b1000: r = {4'h0, a} - {4'h0, b};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_stage_r <= 8'h00;
            alu_out     <= 8'h00;
        end else begin
            alu_stage_r <= alu_lane(sel_vec, op_a, op_b);
            alu_out     <= alu_stage_r;
        end
    end

    // Reference: what the consumer must receive for a command.
    function automatic exp_t ref_model(input logic [1:0] op, input logic [OP_W-1:0] a,
                                       input logic [OP_W-1:0] b);
        exp_t e;
        int   ra;
        int   rb;
        int   r;
        ra = int'(a);
        rb = int'(b);
        e.op  = op;
        e.a   = a;
        e.b   = b;
        e.err = 1'b0;
        case (op)
            2'd0: r = ra * rb;
            2'd1: r = ra + rb;
            2'd2: begin
                if (rb == 0) begin
                    r     = 255;
                    e.err = 1'b1;
                end else begin
                    r = ra / rb;
                end
            end
            default: r = (ra - rb + 256) % 256;
        endcase
        e.data = 8'(r);
        return e;
    endfunction

    function automatic logic [3:0] exp_sel(input exp_t e);
        if (e.err) return 4'b0000;
        return 4'b0001 << e.op;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Monitor: lane/operand correctness, isolation, 2-cycle select width, results.
    always @(negedge clk) begin
        if (!rst) begin
            sel_run  <= 0;
            sel_prev <= 1'b0;
        end else begin
            if (sel_vec != 4'b0000) begin
                check("sel_onehot", 32'($countones(sel_vec)), 32'd1);
                check("sel_has_cmd", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("sel_lane", 32'(sel_vec), 32'(exp_sel(exp_q[0])));
                    check("op_a", 32'(op_a), 32'(exp_q[0].a));
                    check("op_b", 32'(op_b), 32'(exp_q[0].b));
                end
                sel_run <= sel_run + 1;
            end else begin
                check("idle_operands", 32'({op_a, op_b}), 32'd0);
                if (sel_prev) begin
                    check("sel_width", 32'(sel_run), 32'd2);
                end
                sel_run <= 0;
            end
            sel_prev <= (sel_vec != 4'b0000);
            if (bus.res_valid && bus.res_ready) begin
                check("res_has_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("res_data", 32'(bus.res_data), 32'(exp_q[0].data));
                    check("res_err", 32'(bus.res_err), 32'(exp_q[0].err));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Drive one command and wait (bounded) for it to be accepted.
    task automatic push(input logic [1:0] op, input logic [OP_W-1:0] a,
                        input logic [OP_W-1:0] b, input bit rnd_ready);
        int n;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        n = 0;
        if (rnd_ready) bus.res_ready = ($urandom_range(0, 3) != 0);
        while (!bus.cmd_ready && n < 200) begin
            @(posedge clk); #1;
            if (rnd_ready) bus.res_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        check("cmd_accept", 32'(bus.cmd_ready), 32'd1);
        if (bus.cmd_ready) begin
            exp_q.push_back(ref_model(op, a, b));
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for res_valid; reports edges waited.
    task automatic wait_res(output int n);
        n = 0;
        while (!bus.res_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("res_valid_arrives", 32'(bus.res_valid), 32'd1);
    endtask

    // Drain everything with res_ready held high.
    task automatic wait_idle();
        int n;
        bus.res_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || busy || bus.res_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drained", 32'(exp_q.size() == 0 && !busy), 32'd1);
    endtask

    initial begin
        int         lat;
        logic [7:0] held;
        logic [1:0] rop;
        logic [3:0] ra;
        logic [3:0] rb;

        tests         = 0;
        fails         = 0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_a     = 4'h0;
        bus.cmd_b     = 4'h0;
        bus.res_ready = 1'b1;
        rst           = 1'b1;
        #2 rst = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_sel", 32'(sel_vec), 32'd0);
        check("rst_op_a", 32'(op_a), 32'd0);
        check("rst_op_b", 32'(op_b), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_res_err", 32'(bus.res_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        // MUL 7*9: latency 4 edges, 8'h3F
        push(2'd0, 4'd7, 4'd9, 1'b0);
        check("busy_after_push", 32'(busy), 32'd1);
        wait_res(lat);
        check("mul_latency", 32'(lat), 32'd4);
        check("mul_data", 32'(bus.res_data), 32'h3F);
        check("mul_err", 32'(bus.res_err), 32'd0);
        wait_idle();
        check("mul_after_sel", 32'(sel_vec), 32'd0);
        check("mul_after_ops", 32'({op_a, op_b}), 32'd0);

        // ADD 15+15, DIV 13/4, SUB 3-5 back-to-back
        push(2'd1, 4'd15, 4'd15, 1'b0);
        push(2'd2, 4'd13, 4'd4, 1'b0);
        push(2'd3, 4'd3, 4'd5, 1'b0);
        wait_idle();

        // DIV by zero then ADD 1+1
        push(2'd2, 4'd6, 4'd0, 1'b0);
        wait_res(lat);
        check("div0_latency", 32'(lat), 32'd4);
        check("div0_data", 32'(bus.res_data), 32'hFF);
        check("div0_err", 32'(bus.res_err), 32'd1);
        push(2'd1, 4'd1, 4'd1, 1'b0);
        wait_res(lat);
        check("add11_data", 32'(bus.res_data), 32'h02);
        check("add11_err", 32'(bus.res_err), 32'd0);
        wait_idle();

        // Backpressure: hold first result, fill FIFO, cmd_ready must drop
        bus.res_ready = 1'b0;
        push(2'd0, 4'd2, 4'd3, 1'b0);
        wait_res(lat);
        held = bus.res_data;
        check("bp_first_data", 32'(held), 32'h06);
        push(2'd1, 4'd4, 4'd4, 1'b0);
        push(2'd3, 4'd9, 4'd2, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd2;
        bus.cmd_a     = 4'd15;
        bus.cmd_b     = 4'd3;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("bp_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
            check("bp_res_stable", 32'(bus.res_data), 32'(held));
            check("bp_res_valid", 32'(bus.res_valid), 32'd1);
            check("bp_busy", 32'(busy), 32'd1);
        end
        bus.res_ready = 1'b1;
        push(2'd2, 4'd15, 4'd3, 1'b0);
        wait_idle();

        // Reset during HOLD of MUL 5*5 with one queued command
        push(2'd0, 4'd5, 4'd5, 1'b0);
        push(2'd1, 4'd2, 4'd2, 1'b0);
        @(posedge clk); #1;
        check("hold_sel1", 32'(sel_vec), 32'd1);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_sel", 32'(sel_vec), 32'd0);
        check("midrst_ops", 32'({op_a, op_b}), 32'd0);
        check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        check("midrst_res_data", 32'(bus.res_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("postrst_busy", 32'(busy), 32'd0);
        check("postrst_res_valid", 32'(bus.res_valid), 32'd0);

        // Randomized commands with random result backpressure
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 4'($urandom_range(0, 15));
            rb  = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            push(rop, ra, rb, 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                bus.res_ready = ($urandom_range(0, 3) != 0);
            end
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
